pe_intt_gs: RTL

Streaming inverse-NTT processing element, the inverse-direction counterpart of the forward PE in the NTT datapath. It consumes coefficient pairs (a, b) serially and applies the Gentleman-Sande butterfly with the 1/2 scaling folded in: a' = (a+b)/2 mod q, b' = ((a-b)·w⁻¹)/2 mod q. Results stream out serially (a' then b') at one sample per cycle.

---
 rtl/ntt_pkg.sv | 42 ++++
 rtl/mod_mult.sv | 36 +++
 rtl/shift_reg.sv | 28 ++
 rtl/pe_intt_gs.sv | 114 +++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and modular-arithmetic helpers for the NTT datapath.
// All helpers work at W+1 bits internally so carries and borrows are never lost.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif

package ntt_pkg;

  localparam int W = `DATA_SIZE_ARB;

  typedef logic [W-1:0] coeff_t;

  function automatic coeff_t mod_add(coeff_t a, coeff_t b, coeff_t q);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) begin
      s = s - {1'b0, q};
    end
    return s[W-1:0];
  endfunction

  // A borrow shows up in the extra top bit; adding q back wraps into range.
  function automatic coeff_t mod_sub(coeff_t a, coeff_t b, coeff_t q);
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[W]) begin
      d = d + {1'b0, q};
    end
    return d[W-1:0];
  endfunction

  // Division by two mod an odd q: odd values become even by adding q first.
  function automatic coeff_t mod_half(coeff_t x, coeff_t q);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, q};
    if (x[0]) begin
      return s[W:1];
    end
    return {1'b0, x[W-1:1]};
  endfunction

endpackage

// File: rtl/mod_mult.sv
// Pipelined modular multiplier: p = (a * b) mod q, LAT cycles after a/b/q are presented.
// Datapath only; the caller tracks validity with its own pipeline.
module mod_mult #(
  parameter int W   = 16,
  parameter int LAT = 7
) (
  input  logic         clk,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  output logic [W-1:0] p
);

  logic [2*W-1:0] prod_full;
  logic [2*W-1:0] prod_mod;
  logic [W-1:0]   stage_reg [LAT];

  assign prod_full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign prod_mod  = prod_full % {{W{1'b0}}, q};

  always_ff @(posedge clk) begin
    stage_reg[0] <= prod_mod[W-1:0];
  end

  genvar gi;
  generate
    for (gi = 1; gi < LAT; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  endgenerate

  assign p = stage_reg[LAT-1];

endmodule

// File: rtl/shift_reg.sv
// Fixed-depth delay line without reset; contents are qualified by a separate valid pipeline.
module shift_reg #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 7
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] tap_reg [DEPTH];

  always_ff @(posedge clk) begin
    tap_reg[0] <= din;
  end

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_tap
      always_ff @(posedge clk) begin
        tap_reg[gi] <= tap_reg[gi-1];
      end
    end
  endgenerate

  assign dout = tap_reg[DEPTH-1];

endmodule

// File: rtl/pe_intt_gs.sv
// Streaming inverse-NTT processing element: Gentleman-Sande butterfly with the 1/2 folded in.
// Pairs (a, b) arrive serially; a' = (a+b)/2 and b' = ((a-b)*w_inv)/2 leave on consecutive cycles.
module pe_intt_gs
  import ntt_pkg::*;
#(
  parameter int MULT_LAT = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] q,
  input  logic [W-1:0] data_i,
  input  logic [W-1:0] twiddle_i,
  output logic [W-1:0] intt_o,
  output logic         valid_o
);

  logic           phase_reg;
  coeff_t         a_reg;
  coeff_t         tw_reg;
  coeff_t         sum_reg;
  coeff_t         diff_reg;
  logic           pv1_reg;
  coeff_t         hold_reg;
  logic           hold_vld_reg;
  logic [MULT_LAT:0] vld_chain;
  coeff_t         sum_dly;
  coeff_t         prod;

  // Input capture and butterfly add/subtract stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_reg <= 1'b0;
      a_reg     <= '0;
      tw_reg    <= '0;
      sum_reg   <= '0;
      diff_reg  <= '0;
      pv1_reg   <= 1'b0;
    end else begin
      pv1_reg <= 1'b0;
      if (start) begin
        phase_reg <= ~phase_reg;
        if (!phase_reg) begin
          a_reg <= data_i;
        end else begin
          tw_reg   <= twiddle_i;
          sum_reg  <= mod_add(a_reg, data_i, q);
          diff_reg <= mod_sub(a_reg, data_i, q);
          pv1_reg  <= 1'b1;
        end
      end
    end
  end

  mod_mult #(
    .W   (W),
    .LAT (MULT_LAT)
  ) u_mod_mult (
    .clk (clk),
    .a   (diff_reg),
    .b   (tw_reg),
    .q   (q),
    .p   (prod)
  );

  shift_reg #(
    .WIDTH (W),
    .DEPTH (MULT_LAT)
  ) u_sum_dly (
    .clk  (clk),
    .din  (sum_reg),
    .dout (sum_dly)
  );

  // Valid bits track the multiplier/delay-line depth and are the only reset-protected state there.
  assign vld_chain[0] = pv1_reg;

  genvar gi;
  generate
    for (gi = 1; gi <= MULT_LAT; gi++) begin : g_vld
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_chain[gi] <= 1'b0;
        end else begin
          vld_chain[gi] <= vld_chain[gi-1];
        end
      end
    end
  endgenerate

  // Output serialiser: a' goes out directly, b' waits one cycle in hold_reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      intt_o       <= '0;
      valid_o      <= 1'b0;
      hold_reg     <= '0;
      hold_vld_reg <= 1'b0;
    end else begin
      if (vld_chain[MULT_LAT]) begin
        intt_o       <= mod_half(sum_dly, q);
        hold_reg     <= mod_half(prod, q);
        hold_vld_reg <= 1'b1;
        valid_o      <= 1'b1;
      end else if (hold_vld_reg) begin
        intt_o       <= hold_reg;
        hold_vld_reg <= 1'b0;
        valid_o      <= 1'b1;
      end else begin
        valid_o      <= 1'b0;
      end
    end
  end

endmodule
